// File: rtl/trdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trdb_pkg                                                     |
// | Description : Shared types and defaults for the trace packet scheduler     |
// |               and its branch map.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package trdb_pkg;

    // Packet format, encoded as in the packet header.
    typedef enum logic [1:0] {
        F0 = 2'b00,
        F1 = 2'b01,
        F2 = 2'b10,
        F3 = 2'b11
    } trdb_format_e;

    // Format 3 subformat; zero for every other format.
    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_subformat_e;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_TRACE = 2'd2,
        ST_DRAIN = 2'd3
    } trdb_sched_state_e;

    // Branch-map capacity; the 5-bit count limits this to 31.
    localparam int unsigned BMAP_LEN_DEFAULT = 31;

endpackage
`default_nettype wire

// File: rtl/trdb_packet_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trdb_packet_scheduler_if                                     |
// | Description : Retired-instruction stream plus packet request bus of the    |
// |               scheduler.                                                   |
// |   slave  : the scheduler (consumes instructions, drives pkt_* / stall_o)   |
// |   master : the environment (instruction source and packet emitter)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface trdb_packet_scheduler_if
    import trdb_pkg::*;
#(
    parameter int unsigned BMAP_LEN = BMAP_LEN_DEFAULT
) ();

    // Instruction source side
    logic                trace_enable_i;
    logic                inst_valid_i;
    logic                is_branch_i;
    logic                is_branch_taken_i;
    logic                exception_i;
    logic                context_change_i;
    logic                updiscon_i;
    logic                stall_o;

    // Emitter side
    logic                pkt_valid_o;
    logic                pkt_ready_i;
    trdb_format_e        pkt_format_o;
    trdb_subformat_e     pkt_subformat_o;
    logic [BMAP_LEN-1:0] branch_map_o;
    logic [4:0]          branch_cnt_o;

    modport slave (
        input  trace_enable_i, inst_valid_i, is_branch_i, is_branch_taken_i,
               exception_i, context_change_i, updiscon_i, pkt_ready_i,
        output stall_o, pkt_valid_o, pkt_format_o, pkt_subformat_o,
               branch_map_o, branch_cnt_o
    );

    modport master (
        output trace_enable_i, inst_valid_i, is_branch_i, is_branch_taken_i,
               exception_i, context_change_i, updiscon_i, pkt_ready_i,
        input  stall_o, pkt_valid_o, pkt_format_o, pkt_subformat_o,
               branch_map_o, branch_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/trdb_branch_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trdb_branch_map                                              |
// | Description : Accumulates branch outcomes (1 = not taken, bit 0 oldest).   |
// |               The snapshot outputs already contain the branch pushed this  |
// |               cycle, so a packet triggered by that same instruction        |
// |               carries it while the stored map restarts empty.              |
// | Ports       : clk_i, rst_ni (sync, active-low)                             |
// |               push_i/taken_i : record one branch outcome                   |
// |               clear_i        : empty the stored map after this cycle       |
// |               full_o         : snapshot count equals BMAP_LEN              |
// |               snap_map_o/snap_cnt_o : map and count including this push    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int unsigned BMAP_LEN = BMAP_LEN_DEFAULT
) (
    input  wire logic                clk_i,
    input  wire logic                rst_ni,
    input  wire logic                push_i,
    input  wire logic                taken_i,
    input  wire logic                clear_i,
    output logic                     full_o,
    output logic [BMAP_LEN-1:0]      snap_map_o,
    output logic [4:0]               snap_cnt_o
);

    localparam logic [4:0] c_len = 5'(BMAP_LEN);

    logic [BMAP_LEN-1:0] map_q, map_d;
    logic [4:0]          cnt_q, cnt_d;

    // Snapshot path: stored map with this cycle's branch inserted.
    always_comb begin
        snap_map_o = map_q;
        snap_cnt_o = cnt_q;
        if (push_i && (cnt_q < c_len)) begin
            for (int i = 0; i < BMAP_LEN; i++) begin
                if (cnt_q == 5'(i)) begin
                    snap_map_o[i] = ~taken_i;
                end
            end
            snap_cnt_o = cnt_q + 5'd1;
        end
    end

    assign full_o = (snap_cnt_o == c_len);

    // A clear wins over a push: the pushed branch leaves through the snapshot.
    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            map_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            map_d = snap_map_o;
            cnt_d = snap_cnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trdb_packet_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trdb_packet_scheduler                                        |
// | Description : Decides when a trace packet is due and which format it has,  |
// |               collects the branch map and hands requests to the emitter    |
// |               over a valid/ready handshake, stalling the instruction       |
// |               source while a request is not accepted.                      |
// | Ports       : clk_i, rst_ni (sync, active-low)                             |
// |               bus (slave): instruction stream in, stall_o out,             |
// |                            pkt_valid_o/pkt_ready_i handshake, format,      |
// |                            subformat, branch map and count out             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_MAX = 256,
    parameter int unsigned BMAP_LEN   = BMAP_LEN_DEFAULT
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    trdb_packet_scheduler_if.slave  bus
);

    localparam int unsigned    c_rs_w   = $clog2(RESYNC_MAX + 1);
    localparam logic [c_rs_w-1:0] c_rs_max = c_rs_w'(RESYNC_MAX);

    // State and registered outputs
    trdb_sched_state_e   state_q, state_d;
    logic [c_rs_w-1:0]   resync_cnt_q, resync_cnt_d;
    logic                pkt_valid_q, pkt_valid_d;
    trdb_format_e        fmt_q, fmt_d;
    trdb_subformat_e     sub_q, sub_d;
    logic [BMAP_LEN-1:0] map_q, map_d;
    logic [4:0]          cnt_q, cnt_d;

    // Combinational helpers
    logic                w_stall;
    logic                w_acc;
    logic                w_done;
    logic                w_tracing;
    logic                w_bm_push;
    logic                w_bm_full;
    logic [BMAP_LEN-1:0] w_snap_map;
    logic [4:0]          w_snap_cnt;
    logic [c_rs_w-1:0]   w_resync_upd;
    logic                w_resync_hit;
    logic                w_req;
    trdb_format_e        w_req_fmt;
    trdb_subformat_e     w_req_sub;

    assign w_stall   = pkt_valid_q & ~bus.pkt_ready_i;
    assign w_acc     = bus.inst_valid_i & ~w_stall & bus.trace_enable_i;
    assign w_done    = pkt_valid_q & bus.pkt_ready_i;
    assign w_tracing = (state_q == ST_START) || (state_q == ST_TRACE);
    assign w_bm_push = w_acc & w_tracing & bus.is_branch_i;

    // Resync decision uses the count including the current instruction.
    assign w_resync_upd = (resync_cnt_q == c_rs_max) ? resync_cnt_q
                                                     : resync_cnt_q + 1'b1;
    assign w_resync_hit = (w_resync_upd == c_rs_max);

    trdb_branch_map #(
        .BMAP_LEN (BMAP_LEN)
    ) u_branch_map (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_bm_push),
        .taken_i    (bus.is_branch_taken_i),
        .clear_i    (w_req),
        .full_o     (w_bm_full),
        .snap_map_o (w_snap_map),
        .snap_cnt_o (w_snap_cnt)
    );

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.trace_enable_i) state_d = ST_START;
            end
            ST_START: begin
                // Disabled before anything was traced: nothing to report.
                if (w_acc)                        state_d = ST_TRACE;
                else if (!bus.trace_enable_i)     state_d = ST_IDLE;
            end
            ST_TRACE: begin
                // The support packet waits until the output register is free.
                if (!bus.trace_enable_i && !w_stall) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs (packet request)
    always_comb begin
        w_req     = 1'b0;
        w_req_fmt = F0;
        w_req_sub = SF_START;
        case (state_q)
            ST_START: begin
                if (w_acc) begin
                    w_req     = 1'b1;
                    w_req_fmt = F3;
                    w_req_sub = SF_START;
                end
            end
            ST_TRACE: begin
                if (!bus.trace_enable_i) begin
                    if (!w_stall) begin
                        w_req     = 1'b1;
                        w_req_fmt = F3;
                        w_req_sub = SF_SUPPORT;
                    end
                end else if (w_acc) begin
                    if (bus.exception_i) begin
                        w_req     = 1'b1;
                        w_req_fmt = F3;
                        w_req_sub = SF_TRAP;
                    end else if (bus.context_change_i) begin
                        w_req     = 1'b1;
                        w_req_fmt = F3;
                        w_req_sub = SF_CONTEXT;
                    end else if (w_resync_hit) begin
                        w_req     = 1'b1;
                        w_req_fmt = F3;
                        w_req_sub = SF_START;
                    end else if (bus.updiscon_i) begin
                        w_req     = 1'b1;
                        w_req_fmt = (w_snap_cnt == 5'd0) ? F2 : F1;
                    end else if (w_bm_full) begin
                        w_req     = 1'b1;
                        w_req_fmt = F1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- resync counter
    always_comb begin
        resync_cnt_d = resync_cnt_q;
        if (w_req && (w_req_fmt == F3)) begin
            resync_cnt_d = '0;
        end else if (w_acc) begin
            resync_cnt_d = w_resync_upd;
        end
    end

    // ---------------------------------------------------------------- packet output register
    // A request is only raised when the register is free (w_stall low), so
    // the fields never change under a pending, unaccepted request.
    always_comb begin
        pkt_valid_d = pkt_valid_q;
        fmt_d       = fmt_q;
        sub_d       = sub_q;
        map_d       = map_q;
        cnt_d       = cnt_q;
        if (w_req) begin
            pkt_valid_d = 1'b1;
            fmt_d       = w_req_fmt;
            sub_d       = w_req_sub;
            map_d       = w_snap_map;
            cnt_d       = w_snap_cnt;
        end else if (w_done) begin
            pkt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resync_cnt_q <= '0;
            pkt_valid_q  <= 1'b0;
            fmt_q        <= F0;
            sub_q        <= SF_START;
            map_q        <= '0;
            cnt_q        <= '0;
        end else begin
            resync_cnt_q <= resync_cnt_d;
            pkt_valid_q  <= pkt_valid_d;
            fmt_q        <= fmt_d;
            sub_q        <= sub_d;
            map_q        <= map_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.stall_o         = w_stall;
    assign bus.pkt_valid_o     = pkt_valid_q;
    assign bus.pkt_format_o    = fmt_q;
    assign bus.pkt_subformat_o = sub_q;
    assign bus.branch_map_o    = map_q;
    assign bus.branch_cnt_o    = cnt_q;

endmodule
`default_nettype wire

// File: doc/trdb_packet_scheduler.md
# trdb_packet_scheduler

Sequencing controller in front of `trdb_packet_emitter`. It observes the retired-instruction stream and encoder control and decides when a packet is due and which format/subformat it is: format 3 sf0/1/2/3, format 2 or format 1. It accumulates the branch map that goes into the packet and holds a valid/ready handshake toward the emitter. When the emitter is busy, it back-pressures the instruction source.

## Interface
Parameters:
- `RESYNC_MAX`, default 256: accepted instructions since the last format 3 packet before a resync (f3 sf0) is forced.
- `BMAP_LEN`, default 31: branch-map capacity; the map counts as full at this value.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `trace_enable_i` in 1: encoder enabled (ienable).
- `inst_valid_i` in 1: retired-instruction info is valid this cycle.
- `is_branch_i` in 1: the instruction is a conditional branch.
- `is_branch_taken_i` in 1: the branch was taken.
- `exception_i` in 1: exception or interrupt on this instruction.
- `context_change_i` in 1: privilege or context change.
- `updiscon_i` in 1: uninferable discontinuity follows this instruction.
- `stall_o` out 1: instruction not consumed; the source must hold it.
- `pkt_valid_o` out 1: packet request to the emitter.
- `pkt_ready_i` in 1: emitter accepts the request.
- `pkt_format_o` out `trdb_format_e`: packet format.
- `pkt_subformat_o` out `trdb_subformat_e`: subformat (format 3 only, otherwise 0).
- `branch_map_o` out `BMAP_LEN`: branch map; bit 0 is the oldest branch; 1 = not taken.
- `branch_cnt_o` out 5: number of valid bits in `branch_map_o`.

## Operation
- Accepted instruction: `acc = inst_valid_i & ~stall_o & trace_enable_i`.
- FSM states:
  - IDLE: tracing off.
  - START: first instruction pending.
  - TRACE.
  - DRAIN: a disable was seen and the support packet is pending.
- FSM transitions:
  - IDLE→START when `trace_enable_i` is 1.
  - START→TRACE when the first `acc` occurs; this emits f3 sf0.
  - TRACE→DRAIN when `trace_enable_i` falls; this emits f3 sf3, and the current map goes with it.
  - DRAIN→IDLE when the packet handshake completes.
- Branch map update on `acc & is_branch_i`: write bit `~is_branch_taken_i` at index `branch_cnt`, then increment the count. This update is applied before trigger evaluation, so a packet triggered by the same instruction includes that branch.
- Trigger priority in TRACE on `acc` (highest first; one packet per instruction):
  1. `exception_i` → f3 sf1.
  2. `context_change_i` → f3 sf2.
  3. Resync counter reached `RESYNC_MAX` → f3 sf0.
  4. `updiscon_i` → format 2 if the updated count is 0, else format 1.
  5. Updated count equals `BMAP_LEN` → format 1.
- Snapshot rule: when a packet is requested, `branch_map_o`/`branch_cnt_o` take the snapshot. The internal map is cleared to 0, and a branch from this same instruction goes into the snapshot, not the new map.
- Resync counter:
  - Increments on every `acc` and saturates at `RESYNC_MAX`.
  - Clears when any format 3 packet is requested.
- `pkt_*` outputs are registered and stay stable while `pkt_valid_o & ~pkt_ready_i`.
- `stall_o = pkt_valid_o & ~pkt_ready_i`, combinational. A new trigger can therefore be taken in the same cycle an old packet is accepted.

## Timing
- Reset values: `pkt_valid_o`=0, `pkt_format_o`=F0, `pkt_subformat_o`=SF0, `branch_map_o`=0, `branch_cnt_o`=0, `stall_o`=0. FSM in IDLE, resync counter 0.
- Latency: `pkt_valid_o` rises in the cycle after the triggering `acc`.
- Handshake: completes in the cycle where `pkt_valid_o & pkt_ready_i`. `pkt_valid_o` drops in the next cycle unless a new trigger occurs in the completion cycle.
- Back-to-back triggers: one packet per cycle is sustainable when `pkt_ready_i` is held at 1.
- Disable while `pkt_valid_o` is pending: the current packet completes first, then the f3 sf3 packet is issued.
- Map full with no trigger and no branch: impossible by construction; the map is emitted at `BMAP_LEN`.
- Reset asserted mid-handshake: everything returns to reset values on the next edge, and the pending packet is dropped.

## Structure
- Shared `trdb_pkg` holds:
  - `trdb_format_e` (F0..F3 = 2'b00..2'b11).
  - `trdb_subformat_e` (SF_START=0, SF_TRAP=1, SF_CONTEXT=2, SF_SUPPORT=3).
  - New `trdb_sched_state_e`.
  - Default `BMAP_LEN`.
- Sub-module `trdb_branch_map`: holds the map and count, with push, clear, a full flag and a snapshot path.
- The FSM, priority logic, resync counter and output register live in the top module.

## Test plan
- Enable, then one `acc` (non-branch) → f3 sf0 one cycle later, `branch_cnt_o`=0, resync counter at 0.
- 31 branches alternating taken/not-taken → format 1 with `branch_cnt_o`=31 and `branch_map_o`=0x2AAAAAAA if the first branch was taken; the next map starts empty.
- 3 branches, then a fourth branch with `updiscon_i` → format 1 with count 4. Then `updiscon_i` with no branches → format 2 with count 0.
- Same instruction has `exception_i`, `updiscon_i` and a full map → only f3 sf1 is emitted, and the map snapshot goes with it.
- `pkt_ready_i` held at 0 for 5 cycles with `inst_valid_i`=1 → `stall_o`=1 and packet fields stable for 5 cycles, no instruction consumed. On ready, the next trigger appears in the following cycle.
- `RESYNC_MAX`=8: 8 plain `acc` → f3 sf0. Drop `trace_enable_i` → f3 sf3, then IDLE. Assert reset mid-handshake → all outputs 0 on the next edge.
